parity_combination_scanner: RTL and testbench
=============================================

Name: parity_combination_scanner

Overview:
- Search stage that feeds the DFS solver's stack on each recursion step.
- Given a joltage target vector and a starting button combination, scans combinations upward, one per cycle.
- Stops at the first combination whose per-counter press sums match target parity and do not exceed the target.
- Returns the halved residual target, the combination's popcount and the resume point. The controller pushes these values, or pops on exhaustion.

Parameters:
- MACHINE_COUNT, 10: number of joltage counters in the target vector.
- MAX_BUTTON_COUNT, 13: maximum number of buttons.
- BITS_PER_JOLTAGE, 9: width of one counter's target.
- ANSWER_BIT_WIDTH, 16: width of the press count.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  pulse; accepted only when busy=0.
- abort  in  1  pulse; cancels the scan in progress.
- start_combination  in  MAX_BUTTON_COUNT+1  first combination to evaluate.
- button_count  in  $clog2(MAX_BUTTON_COUNT+1)  buttons in use, 0..MAX_BUTTON_COUNT.
- button_masks  in  MAX_BUTTON_COUNT*MACHINE_COUNT  slice [b*MACHINE_COUNT +: MACHINE_COUNT] gives the counters button b increments.
- target  in  MACHINE_COUNT*BITS_PER_JOLTAGE  counter j at [j*BITS_PER_JOLTAGE +: BITS_PER_JOLTAGE].
- busy  out  1  high while scanning.
- done  out  1  one-cycle pulse when a scan finishes.
- found  out  1  1 = match found; 0 = combinations exhausted.
- found_combination  out  MAX_BUTTON_COUNT+1  matching combination.
- next_combination  out  MAX_BUTTON_COUNT+1  resume point: match+1, or LIMIT on exhaustion.
- reduced_target  out  MACHINE_COUNT*BITS_PER_JOLTAGE  (target_j - sum_j) >> 1 for every counter.
- press_count  out  ANSWER_BIT_WIDTH  popcount(found_combination), zero-extended.

Behaviour:
- LIMIT = 1 << button_count.
- States: IDLE and SCAN.
- Reset (asynchronous, reset=0): state IDLE, internal registers cleared, every output 0. Applies mid-scan with no done pulse.
- IDLE:
  - start=1 latches target, button_masks and button_count.
  - cur <= start_combination; go to SCAN; busy=1 from the next cycle.
- SCAN: one evaluation of cur per clock.
  - If cur >= LIMIT (including when bit MAX_BUTTON_COUNT is set):
    - done<=1, found<=0, next_combination<=LIMIT.
    - found_combination, reduced_target and press_count <= 0.
    - Go to IDLE.
  - Otherwise, for each counter j: sum_j = number of buttons b < button_count with cur[b]=1 and mask bit (b,j)=1.
    - sum_j is computed at BITS_PER_JOLTAGE width and never overflows.
  - Match when, for every counter j: sum_j <= target_j and (target_j - sum_j) is even.
  - On match:
    - done<=1, found<=1, found_combination<=cur, next_combination<=cur+1.
    - reduced_target and press_count are loaded.
    - Go to IDLE.
  - No match: cur <= cur+1 and stay in SCAN.
- Latency: when the first evaluated combination terminates (match or exhaustion), done is high one cycle after the start edge. Each rejected combination adds one cycle.
- After done:
  - busy falls in the same cycle that done rises.
  - Result outputs hold until the next accepted start or reset.
  - Result outputs do not change during a scan.
- Handshake and boundary cases:
  - start while busy=1: ignored.
  - abort in SCAN: go to IDLE on the next edge, no done pulse, outputs unchanged. abort in IDLE: no effect.
  - start and abort together in IDLE: start wins.
  - button_count=0: only combination 0 is valid; LIMIT=1.
  - Counters with target 0 and no mask bits always satisfy the match condition.
  - Mask bits of buttons at or above button_count are ignored.

Test Plan:
- Buttons and masks: b0={3}, b1={1,3}, b2={2}, b3={2,3}, b4={0,2}, b5={0,1}; button_count=6; target counters 0..3 = {3,5,4,7}, others 0; start_combination=0.
  - Required: done 23 cycles after start, found=1, found_combination=22, next_combination=23, press_count=3, reduced_target {1,2,1,3}.
- Same setup, start_combination=23.
  - Required: done after 5 cycles, found_combination=27, next_combination=28, press_count=4, reduced_target {1,2,1,2}.
- Same setup, start_combination=64.
  - Required: done after 1 cycle, found=0, next_combination=64, other results 0.
- All-zero target, start_combination=0, any masks.
  - Required: done after 1 cycle, found=1, combination 0, press_count=0, reduced_target=0.
- button_count=1, b0={0,1}, target {1,0}, start 0.
  - Combination 0 fails parity; combination 1 exceeds counter 1.
  - Required: done after 3 cycles, found=0, next_combination=2.
- Interference cases on the first scenario:
  - Second start pulsed at cycle 5: ignored, and the result still arrives at cycle 23.
  - abort at cycle 10: busy=0 at cycle 11, no done pulse.
  - reset=0 at cycle 10: all outputs 0 immediately.

Source files
------------

// File: rtl/parity_combination_scanner.sv
// Scans button combinations upward, one per cycle, for the first one whose
// per-counter press sums fit under the target with matching parity.
module parity_combination_scanner #(
  parameter int MACHINE_COUNT    = 10,
  parameter int MAX_BUTTON_COUNT = 13,
  parameter int BITS_PER_JOLTAGE = 9,
  parameter int ANSWER_BIT_WIDTH = 16,
  localparam int CW  = MAX_BUTTON_COUNT + 1,
  localparam int BCW = $clog2(MAX_BUTTON_COUNT + 1),
  localparam int MW  = MAX_BUTTON_COUNT * MACHINE_COUNT,
  localparam int TW  = MACHINE_COUNT * BITS_PER_JOLTAGE
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        abort,
  input  logic [CW-1:0]               start_combination,
  input  logic [BCW-1:0]              button_count,
  input  logic [MW-1:0]               button_masks,
  input  logic [TW-1:0]               target,
  output logic                        busy,
  output logic                        done,
  output logic                        found,
  output logic [CW-1:0]               found_combination,
  output logic [CW-1:0]               next_combination,
  output logic [TW-1:0]               reduced_target,
  output logic [ANSWER_BIT_WIDTH-1:0] press_count
);

  localparam int B = BITS_PER_JOLTAGE;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]  cur_q, cur_d;
  logic [TW-1:0]  tgt_q, tgt_d;
  logic [MW-1:0]  msk_q, msk_d;
  logic [BCW-1:0] cnt_q, cnt_d;

  logic                        done_d;
  logic                        found_d;
  logic [CW-1:0]               fc_d;
  logic [CW-1:0]               nc_d;
  logic [TW-1:0]               red_d;
  logic [ANSWER_BIT_WIDTH-1:0] pc_d;

  logic [B-1:0]                sum  [MACHINE_COUNT];
  logic [B-1:0]                diff [MACHINE_COUNT];
  logic [TW-1:0]               red;
  logic [ANSWER_BIT_WIDTH-1:0] pc;
  logic [CW-1:0]               limit;
  logic                        in_range;
  logic                        match;

  assign limit    = CW'(1) << cnt_q;
  assign in_range = cur_q < limit;
  assign busy     = (state_q == SCAN);

  // Bits of cur at or above button_count are zero whenever in_range,
  // so unused buttons drop out without an explicit index compare.
  always_comb begin
    for (int j = 0; j < MACHINE_COUNT; j++) begin
      sum[j] = '0;
      for (int b = 0; b < MAX_BUTTON_COUNT; b++) begin
        if (cur_q[b] && msk_q[b*MACHINE_COUNT+j])
          sum[j] = sum[j] + B'(1);
      end
    end
  end

  always_comb begin
    match = 1'b1;
    red   = '0;
    for (int j = 0; j < MACHINE_COUNT; j++) begin
      diff[j] = tgt_q[j*B +: B] - sum[j];
      if (sum[j] > tgt_q[j*B +: B] || diff[j][0])
        match = 1'b0;
      red[j*B +: B] = {1'b0, diff[j][B-1:1]};
    end
  end

  always_comb begin
    pc = '0;
    for (int b = 0; b < CW; b++)
      pc = pc + ANSWER_BIT_WIDTH'(cur_q[b]);
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    tgt_d   = tgt_q;
    msk_d   = msk_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    found_d = found;
    fc_d    = found_combination;
    nc_d    = next_combination;
    red_d   = reduced_target;
    pc_d    = press_count;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          tgt_d   = target;
          msk_d   = button_masks;
          cnt_d   = button_count;
          cur_d   = start_combination;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (!in_range) begin
          done_d  = 1'b1;
          found_d = 1'b0;
          fc_d    = '0;
          nc_d    = limit;
          red_d   = '0;
          pc_d    = '0;
          state_d = IDLE;
        end else if (match) begin
          done_d  = 1'b1;
          found_d = 1'b1;
          fc_d    = cur_q;
          nc_d    = cur_q + CW'(1);
          red_d   = red;
          pc_d    = pc;
          state_d = IDLE;
        end else begin
          cur_d = cur_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q           <= IDLE;
      cur_q             <= '0;
      tgt_q             <= '0;
      msk_q             <= '0;
      cnt_q             <= '0;
      done              <= 1'b0;
      found             <= 1'b0;
      found_combination <= '0;
      next_combination  <= '0;
      reduced_target    <= '0;
      press_count       <= '0;
    end else begin
      state_q           <= state_d;
      cur_q             <= cur_d;
      tgt_q             <= tgt_d;
      msk_q             <= msk_d;
      cnt_q             <= cnt_d;
      done              <= done_d;
      found             <= found_d;
      found_combination <= fc_d;
      next_combination  <= nc_d;
      reduced_target    <= red_d;
      press_count       <= pc_d;
    end
  end

endmodule

// File: tb/tb_parity_combination_scanner.sv
// Scoreboard bench: reference search model feeds expectations, a monitor
// checks each done pulse against them.
module tb_parity_combination_scanner;

  localparam int MC  = 10;
  localparam int NB  = 13;
  localparam int BPJ = 9;
  localparam int AW  = 16;
  localparam int CW  = NB + 1;
  localparam int BCW = 4;
  localparam int MW  = NB * MC;
  localparam int TW  = MC * BPJ;

  typedef struct packed {
    logic          f;
    logic [CW-1:0] fc;
    logic [CW-1:0] nc;
    logic [TW-1:0] red;
    logic [AW-1:0] pc;
    int            lat;
    int            t0;
  } exp_t;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic [CW-1:0]  start_combination = '0;
  logic [BCW-1:0] button_count = '0;
  logic [MW-1:0]  button_masks = '0;
  logic [TW-1:0]  target = '0;
  logic           busy;
  logic           done;
  logic           found;
  logic [CW-1:0]  found_combination;
  logic [CW-1:0]  next_combination;
  logic [TW-1:0]  reduced_target;
  logic [AW-1:0]  press_count;

  parity_combination_scanner #(
    .MACHINE_COUNT(MC),
    .MAX_BUTTON_COUNT(NB),
    .BITS_PER_JOLTAGE(BPJ),
    .ANSWER_BIT_WIDTH(AW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .abort(abort),
    .start_combination(start_combination),
    .button_count(button_count),
    .button_masks(button_masks),
    .target(target),
    .busy(busy),
    .done(done),
    .found(found),
    .found_combination(found_combination),
    .next_combination(next_combination),
    .reduced_target(reduced_target),
    .press_count(press_count)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];
  exp_t mon_e;
  exp_t ref_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [TW-1:0] act,
                     input logic [TW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Press sum of counter j for combination c using buttons below cnt.
  function automatic int press_sum(input int c, input int cnt,
                                   input logic [MW-1:0] m, input int j);
    int s = 0;
    for (int b = 0; b < cnt; b++)
      if (((c >> b) & 1) == 1 && m[b*MC+j]) s++;
    return s;
  endfunction

  function automatic exp_t model(input int cnt, input logic [MW-1:0] m,
                                 input logic [TW-1:0] t, input int s0);
    exp_t e;
    int   lim;
    bit   ok;
    int   s;
    int   tj;
    e   = '0;
    lim = 1 << cnt;
    for (int c = s0; c < lim; c++) begin
      ok    = 1'b1;
      e.red = '0;
      for (int j = 0; j < MC; j++) begin
        s  = press_sum(c, cnt, m, j);
        tj = int'(t[j*BPJ +: BPJ]);
        if (s > tj || ((tj - s) % 2) != 0) ok = 1'b0;
        else e.red[j*BPJ +: BPJ] = BPJ'((tj - s) / 2);
      end
      if (ok) begin
        e.f   = 1'b1;
        e.fc  = CW'(c);
        e.nc  = CW'(c + 1);
        e.pc  = AW'($countones(c));
        e.lat = c - s0 + 1;
        return e;
      end
    end
    e     = '0;
    e.nc  = CW'(lim);
    e.lat = (s0 >= lim) ? 1 : lim - s0 + 1;
    return e;
  endfunction

  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 want no done");
      end else begin
        mon_e = sb.pop_front();
        chk("found", TW'(found), TW'(mon_e.f));
        chk("found_combination", TW'(found_combination), TW'(mon_e.fc));
        chk("next_combination", TW'(next_combination), TW'(mon_e.nc));
        chk("reduced_target", reduced_target, mon_e.red);
        chk("press_count", TW'(press_count), TW'(mon_e.pc));
        chk("latency", TW'(cyc - mon_e.t0), TW'(mon_e.lat));
        chk("busy_at_done", TW'(busy), '0);
      end
    end
  end

  task automatic issue(input int cnt, input logic [MW-1:0] m,
                       input logic [TW-1:0] t, input int s0,
                       input bit push);
    exp_t e;
    e = model(cnt, m, t, s0);
    @(negedge clk);
    button_count      = BCW'(cnt);
    button_masks      = m;
    target            = t;
    start_combination = CW'(s0);
    start             = 1'b1;
    e.t0              = cyc + 1;
    if (push) begin
      sb.push_back(e);
      ref_e = e;
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 10000) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL timeout: got %0d pending want 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, TW'(busy), '0);
    chk({tag, "_done"}, TW'(done), '0);
    chk({tag, "_found"}, TW'(found), '0);
    chk({tag, "_fc"}, TW'(found_combination), '0);
    chk({tag, "_nc"}, TW'(next_combination), '0);
    chk({tag, "_red"}, reduced_target, '0);
    chk({tag, "_pc"}, TW'(press_count), '0);
  endtask

  logic [MW-1:0] m1;
  logic [TW-1:0] t1;
  logic [MW-1:0] mr;
  logic [TW-1:0] tr;

  initial begin
    m1 = '0;
    m1[0*MC+3] = 1'b1;
    m1[1*MC+1] = 1'b1;
    m1[1*MC+3] = 1'b1;
    m1[2*MC+2] = 1'b1;
    m1[3*MC+2] = 1'b1;
    m1[3*MC+3] = 1'b1;
    m1[4*MC+0] = 1'b1;
    m1[4*MC+2] = 1'b1;
    m1[5*MC+0] = 1'b1;
    m1[5*MC+1] = 1'b1;
    t1 = '0;
    t1[0*BPJ +: BPJ] = BPJ'(3);
    t1[1*BPJ +: BPJ] = BPJ'(5);
    t1[2*BPJ +: BPJ] = BPJ'(4);
    t1[3*BPJ +: BPJ] = BPJ'(7);

    repeat (2) @(negedge clk);
    chk_zero("reset");
    reset = 1'b1;
    @(negedge clk);

    issue(6, m1, t1, 0, 1'b1);
    drain();
    issue(6, m1, t1, 23, 1'b1);
    drain();
    issue(6, m1, t1, 64, 1'b1);
    drain();

    for (int i = 0; i < MW; i++) mr[i] = 1'($urandom_range(0, 1));
    issue(6, mr, '0, 0, 1'b1);
    drain();

    mr = '0;
    mr[0] = 1'b1;
    mr[1] = 1'b1;
    tr = '0;
    tr[0 +: BPJ] = BPJ'(1);
    issue(1, mr, tr, 0, 1'b1);
    drain();

    // Second start mid-scan must be ignored.
    issue(6, m1, t1, 0, 1'b1);
    repeat (4) @(negedge clk);
    start_combination = CW'(23);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();

    // Abort mid-scan: no done, results keep the previous scan's values.
    issue(6, m1, t1, 0, 1'b0);
    repeat (9) @(negedge clk);
    chk("busy_before_abort", TW'(busy), TW'(1));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("busy_after_abort", TW'(busy), '0);
    repeat (30) @(negedge clk);
    chk("abort_found", TW'(found), TW'(ref_e.f));
    chk("abort_fc", TW'(found_combination), TW'(ref_e.fc));
    chk("abort_nc", TW'(next_combination), TW'(ref_e.nc));

    // Reset mid-scan clears everything at once.
    issue(6, m1, t1, 0, 1'b0);
    repeat (9) @(negedge clk);
    #1 reset = 1'b0;
    #1 chk_zero("midreset");
    @(negedge clk);
    reset = 1'b1;
    repeat (30) @(negedge clk);
    chk("post_reset_found", TW'(found), '0);

    for (int k = 0; k < 40; k++) begin
      int cnt;
      int lim;
      int r;
      int s0;
      cnt = int'($urandom_range(0, 8));
      lim = 1 << cnt;
      for (int i = 0; i < MW; i++) mr[i] = 1'($urandom_range(0, 1));
      r  = int'($urandom_range(0, lim - 1));
      tr = '0;
      for (int j = 0; j < MC; j++) begin
        int extra;
        extra = 2 * int'($urandom_range(0, 3));
        if ($urandom_range(0, 3) == 0) extra = extra + 1;
        tr[j*BPJ +: BPJ] = BPJ'(press_sum(r, cnt, mr, j) + extra);
      end
      s0 = int'($urandom_range(0, lim));
      if ($urandom_range(0, 9) == 0) s0 = int'($urandom_range(0, 16383));
      issue(cnt, mr, tr, s0, 1'b1);
      drain();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
